ofm_collector: RTL and testbench

- Consumer end of the conv2d_3x3 result interface: accepts the per-column `sum`/`sum_valid` outputs of the PE array.
- Buffers each column in its own FIFO, then drains all columns round-robin onto one valid/ready output stream.
- Tags each output word with its column index and an end-of-tile-line flag.
- Sits between conv2d_3x3 and the OFM write-back path; replaces bench-side per-column queues in synthesizable form.

---
 rtl/ofm_pkg.sv | 13 +
 rtl/ofm_collector_if.sv | 18 +
 rtl/ofm_col_fifo.sv | 48 ++++
 rtl/ofm_collector.sv | 118 +++++++++++
 tb/tb_ofm_collector.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_pkg.sv
// Shared types and sizing helpers for the OFM collector slice.
package ofm_pkg;
  localparam int DEF_OFM_WIDTH = 25;
  localparam int DEF_COL       = 4;
  localparam int COL_IDX_W     = $clog2(DEF_COL);

  typedef logic signed [DEF_OFM_WIDTH-1:0] sum_t;

  // Index width that stays >= 1 so single-entry configurations still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ofm_collector_if.sv
// Tagged valid/ready output stream of the OFM collector.
interface ofm_collector_if
  import ofm_pkg::*;
#(
  parameter int COL       = DEF_COL,
  parameter int OFM_WIDTH = DEF_OFM_WIDTH
);
  localparam int CW = idx_w(COL);

  logic                        out_valid;
  logic                        out_ready;
  logic signed [OFM_WIDTH-1:0] out_data;
  logic [CW-1:0]               out_col;
  logic                        out_last;

  modport master (output out_valid, out_data, out_col, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_col, out_last, output out_ready);
endinterface

// File: rtl/ofm_col_fifo.sv
// Per-column synchronous FIFO; pointers carry a wrap bit so full/empty need no counter.
module ofm_col_fifo
  import ofm_pkg::*;
#(
  parameter int W     = DEF_OFM_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr, rd;
  logic         wr_en;

  assign empty    = (wr == rd);
  assign full     = (wr[PW] != rd[PW]) && (wr[PW-1:0] == rd[PW-1:0]);
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign wr_en    = push && (!full || pop);
  assign drop     = push && !wr_en;
  assign pop_data = mem[rd[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr <= '0;
      rd <= '0;
    end else if (clr) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (wr_en) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr[PW-1:0]] <= push_data;
  end
endmodule

// File: rtl/ofm_collector.sv
// Collects per-column PE sums into FIFOs and drains them round-robin onto one tagged stream.
// Build option: define OFM_COLLECTOR_RELU_EN to clamp negative words to zero at the output register.
module ofm_collector
  import ofm_pkg::*;
#(
  parameter int COL        = DEF_COL,
  parameter int OFM_WIDTH  = DEF_OFM_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int TILE_LEN   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic [COL-1:0]           sum_valid,
  input  logic [COL*OFM_WIDTH-1:0] sum,
  ofm_collector_if.master          ofm,
  output logic [COL-1:0]           ovf,
  output logic                     busy
);
  localparam int CW = idx_w(COL);
  localparam int LW = idx_w(TILE_LEN);

  logic [COL-1:0][OFM_WIDTH-1:0] head;
  logic [COL-1:0]                full, empty, pop, drop;
  logic [COL-1:0][LW-1:0]        cnt;

  logic [CW-1:0]          rr, grant;
  logic                   any, load, at_end;
  logic [OFM_WIDTH-1:0]   sel, load_d;

  logic                   o_valid, o_last;
  logic [OFM_WIDTH-1:0]   o_data;
  logic [CW-1:0]          o_col;

  for (genvar c = 0; c < COL; c++) begin : g_col
    ofm_col_fifo #(.W(OFM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .push      (sum_valid[c]),
      .push_data (sum[c*OFM_WIDTH +: OFM_WIDTH]),
      .pop       (pop[c]),
      .pop_data  (head[c]),
      .full      (full[c]),
      .empty     (empty[c]),
      .drop      (drop[c])
    );
  end

  // Scan from the far end back to rr so the closest non-empty column wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = COL - 1; i >= 0; i--) begin
      int k;
      k = (int'(rr) + i) % COL;
      if (!empty[k]) begin
        grant = CW'(k);
        any   = 1'b1;
      end
    end
  end

  assign load = (!o_valid || ofm.out_ready) && any;

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  assign sel    = head[grant];
  assign at_end = (cnt[grant] == LW'(TILE_LEN - 1));

`ifdef OFM_COLLECTOR_RELU_EN
  assign load_d = sel[OFM_WIDTH-1] ? '0 : sel;
`else
  assign load_d = sel;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_col   <= '0;
      o_last  <= 1'b0;
      rr      <= '0;
      cnt     <= '0;
    end else if (clr) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_col   <= '0;
      o_last  <= 1'b0;
      rr      <= '0;
      cnt     <= '0;
    end else if (load) begin
      o_valid    <= 1'b1;
      o_data     <= load_d;
      o_col      <= grant;
      o_last     <= at_end;
      cnt[grant] <= at_end ? '0 : cnt[grant] + 1'b1;
      rr         <= CW'((int'(grant) + 1) % COL);
    end else if (ofm.out_ready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    ovf <= '0;
    else if (clr) ovf <= '0;
    else          ovf <= ovf | drop;
  end

  assign ofm.out_valid = o_valid;
  assign ofm.out_data  = o_data;
  assign ofm.out_col   = o_col;
  assign ofm.out_last  = o_last;
  assign busy          = (|(~empty)) || o_valid;
endmodule

// File: tb/tb_ofm_collector.sv
// Randomized and directed bench for ofm_collector against a queue-based reference model.
module tb_ofm_collector;
  localparam int COL = 4;
  localparam int W   = 25;
  localparam int D   = 8;
  localparam int TL  = 16;

  typedef struct {
    logic [1:0]          col;
    logic                last;
    logic signed [W-1:0] data;
  } acc_t;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 clr = 1'b0;
  logic [COL-1:0]       sum_valid = '0;
  logic [COL*W-1:0]     sum = '0;
  logic [COL-1:0]       ovf;
  logic                 busy;

  ofm_collector_if #(.COL(COL), .OFM_WIDTH(W)) ofm ();

  ofm_collector #(.COL(COL), .OFM_WIDTH(W), .FIFO_DEPTH(D), .TILE_LEN(TL)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .sum_valid (sum_valid),
    .sum       (sum),
    .ofm       (ofm.master),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] mq [COL][$];
  logic                m_valid;
  logic signed [W-1:0] m_data;
  logic [1:0]          m_col;
  logic                m_last;
  int                  m_rr;
  int                  m_cnt [COL];
  logic [COL-1:0]      m_ovf;
  acc_t                acc [$];

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] x);
`ifdef OFM_COLLECTOR_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic m_busy();
    logic b = m_valid;
    for (int c = 0; c < COL; c++) if (mq[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) begin mq[c].delete(); m_cnt[c] = 0; end
    m_valid = 0; m_data = '0; m_col = '0; m_last = 0; m_rr = 0; m_ovf = '0;
  endtask

  // Applies the collector's rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    int g;
    logic signed [W-1:0] w;
    g = -1;
    w = '0;
    if (clr) begin model_reset(); return; end
    if (!m_valid || ofm.out_ready)
      for (int i = 0; i < COL; i++) begin
        int k = (m_rr + i) % COL;
        if (g < 0 && mq[k].size() > 0) g = k;
      end
    if (g >= 0) w = mq[g].pop_front();
    for (int c = 0; c < COL; c++)
      if (sum_valid[c]) begin
        if (mq[c].size() < D) mq[c].push_back(sum[c*W +: W]);
        else m_ovf[c] = 1'b1;
      end
    if (g >= 0) begin
      m_valid = 1; m_data = relu(w); m_col = 2'(g);
      m_last = (m_cnt[g] == TL - 1);
      m_cnt[g] = (m_cnt[g] + 1) % TL;
      m_rr = (g + 1) % COL;
    end else if (ofm.out_ready) m_valid = 0;
  endtask

  task automatic cycle();
    if (ofm.out_valid && ofm.out_ready)
      acc.push_back('{col: ofm.out_col, last: ofm.out_last, data: ofm.out_data});
    @(posedge clk);
    if (!rstn) model_reset(); else model_edge();
    #1;
  endtask

  task automatic do_clr();
    sum_valid = '0; clr = 1; cycle(); clr = 0; acc.delete();
  endtask

  task automatic test_reset();
    ofm.out_ready = 1'b1;
    model_reset();
    #3;
    checks++;
    if ({ofm.out_valid, ofm.out_data, ofm.out_col, ofm.out_last, ovf, busy} !== '0) begin
      errors++;
      $display("FAIL reset: v=%0b d=%0d c=%0d l=%0b ovf=%b busy=%0b, required all 0",
               ofm.out_valid, ofm.out_data, ofm.out_col, ofm.out_last, ovf, busy);
    end
    cycle(); rstn = 1; cycle();
  endtask

  task automatic test_single();
    do_clr();
    ofm.out_ready = 1;
    sum_valid = 4'b0100; sum = '0; sum[2*W +: W] = -7;
    cycle(); sum_valid = '0;
    checks++;
    if (ofm.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass: out_valid=%0b required 0", ofm.out_valid);
    end
    cycle();
    checks++;
    if ({ofm.out_valid, ofm.out_col, ofm.out_last} !== {1'b1, 2'd2, 1'b0} ||
        ofm.out_data !== relu(-7)) begin
      errors++;
      $display("FAIL single_word: v=%0b c=%0d l=%0b d=%0d, required v=1 c=2 l=0 d=%0d",
               ofm.out_valid, ofm.out_col, ofm.out_last, ofm.out_data, relu(-7));
    end
    cycle();
    checks++;
    if (ofm.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle: v=%0b busy=%0b required 0 0", ofm.out_valid, busy);
    end
  endtask

  task automatic test_fairness();
    do_clr();
    ofm.out_ready = 1;
    sum_valid = '1;
    for (int c = 0; c < COL; c++) sum[c*W +: W] = W'(c * 10);
    cycle(); sum_valid = '0;
    repeat (6) cycle();
    checks++;
    if (acc.size() != COL) begin
      errors++; $display("FAIL fair_count: got %0d words required %0d", acc.size(), COL);
    end else
      for (int i = 0; i < COL; i++) begin
        checks++;
        if (acc[i].col !== 2'(i) || acc[i].data !== W'(i * 10)) begin
          errors++;
          $display("FAIL fair_order[%0d]: col=%0d data=%0d required col=%0d data=%0d",
                   i, acc[i].col, acc[i].data, i, i * 10);
        end
      end
  endtask

  task automatic test_backpressure();
    int n;
    do_clr();
    ofm.out_ready = 0;
    sum_valid = 4'b0011; sum[0 +: W] = 123; sum[W +: W] = -45;
    cycle(); sum_valid = '0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({ofm.out_valid, ofm.out_col} !== {1'b1, 2'd0} || ofm.out_data !== relu(123)) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%0b c=%0d d=%0d required v=1 c=0 d=123",
                 i, ofm.out_valid, ofm.out_col, ofm.out_data);
      end
    end
    ofm.out_ready = 1; acc.delete();
    repeat (4) cycle();
    n = 0;
    foreach (acc[i]) if (acc[i].col == 0) n++;
    checks++;
    if (n != 1 || acc.size() != 2) begin
      errors++; $display("FAIL bp_release: col0 words=%0d total=%0d required 1 and 2", n, acc.size());
    end
  endtask

  task automatic test_overflow();
    do_clr();
    ofm.out_ready = 0;
    for (int k = 0; k < 10; k++) begin
      sum_valid = 4'b0010; sum[W +: W] = W'(100 + k);
      cycle();
      checks++;
      if (ovf[1] !== (k == 9)) begin
        errors++; $display("FAIL ovf_push[%0d]: ovf[1]=%0b required %0b", k, ovf[1], k == 9);
      end
    end
    sum_valid = '0; ofm.out_ready = 1; acc.delete();
    repeat (12) cycle();
    checks++;
    if (acc.size() != 9) begin
      errors++; $display("FAIL ovf_drain: got %0d words required 9", acc.size());
    end else
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (acc[i].data !== W'(100 + i)) begin
          errors++; $display("FAIL ovf_data[%0d]: got %0d required %0d", i, acc[i].data, 100 + i);
        end
      end
    checks++;
    if (ovf[1] !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ovf[1]=%0b required 1", ovf[1]);
    end
    do_clr();
    checks++;
    if (ovf !== '0) begin
      errors++; $display("FAIL ovf_clr: ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_tile_line();
    do_clr();
    ofm.out_ready = 1;
    for (int k = 0; k < 2 * TL; k++) begin
      sum_valid = 4'b1000; sum[3*W +: W] = W'(k);
      cycle();
    end
    sum_valid = '0;
    repeat (4) cycle();
    checks++;
    if (acc.size() != 2 * TL) begin
      errors++; $display("FAIL tile_count: got %0d words required %0d", acc.size(), 2 * TL);
    end else
      for (int i = 0; i < 2 * TL; i++) begin
        checks++;
        if (acc[i].last !== (i == TL - 1 || i == 2 * TL - 1) || acc[i].data !== W'(i)) begin
          errors++;
          $display("FAIL tile_last[%0d]: last=%0b data=%0d required last=%0b data=%0d",
                   i, acc[i].last, acc[i].data, (i == TL - 1 || i == 2 * TL - 1), i);
        end
      end
  endtask

  task automatic test_random();
    do_clr();
    for (int n = 0; n < 2000; n++) begin
      ofm.out_ready = ($urandom_range(3) != 0);
      sum_valid     = COL'($urandom) & COL'($urandom);
      for (int c = 0; c < COL; c++) sum[c*W +: W] = W'($urandom);
      clr = ($urandom_range(199) == 0);
      cycle();
      checks++;
      if ({ofm.out_valid, ofm.out_data, ofm.out_col, ofm.out_last, ovf, busy} !==
          {m_valid, m_data, m_col, m_last, m_ovf, m_busy()}) begin
        errors++;
        $display("FAIL random[%0d]: v=%0b d=%0d c=%0d l=%0b ovf=%b busy=%0b required v=%0b d=%0d c=%0d l=%0b ovf=%b busy=%0b",
                 n, ofm.out_valid, ofm.out_data, ofm.out_col, ofm.out_last, ovf, busy,
                 m_valid, m_data, m_col, m_last, m_ovf, m_busy());
      end
    end
    clr = 0; sum_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_clr();
    ofm.out_ready = 0;
    sum_valid = 4'b0111;
    for (int c = 0; c < COL; c++) sum[c*W +: W] = W'(50 + c);
    cycle(); sum_valid = '0;
    cycle();
    rstn = 0;
    #1;
    checks++;
    if ({ofm.out_valid, ofm.out_data, ofm.out_col, ofm.out_last, ovf, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async: v=%0b d=%0d c=%0d l=%0b ovf=%b busy=%0b required all 0",
               ofm.out_valid, ofm.out_data, ofm.out_col, ofm.out_last, ovf, busy);
    end
    model_reset();
    cycle(); rstn = 1;
    ofm.out_ready = 1; acc.delete();
    repeat (8) cycle();
    checks++;
    if (acc.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_stale: %0d words emerged busy=%0b required 0 0", acc.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_tile_line();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
